// File: rtl/piezo_pkg.sv
// Shared types and helpers for the piezo alert scheduler.
//   tone_sel_t    : code handed to the tone generator (none / 1.5 / 3 / 6.1 kHz)
//   sched_state_t : beep sequencer state
//   max3          : constant helper used to size the shared down-timer
//   pick_req      : fixed-priority arbitration (ovr > batt > norm)
package piezo_pkg;

  typedef enum logic [1:0] {
    TONE_NONE = 2'b00,
    TONE_NORM = 2'b01,
    TONE_BATT = 2'b10,
    TONE_OVR  = 2'b11
  } tone_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } sched_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // norm_req is already gated by mute at the call site.
  function automatic tone_sel_t pick_req(input logic ovr, input logic batt,
                                         input logic norm_req);
    if (ovr)           return TONE_OVR;
    else if (batt)     return TONE_BATT;
    else if (norm_req) return TONE_NORM;
    else               return TONE_NONE;
  endfunction

endpackage

// File: rtl/alert_qual.sv
// Level qualifier for one raw alert input.
// The qualified flag follows raw only after raw has differed from it for
// QUAL_CYC consecutive cycles; shorter excursions are discarded. Works the
// same way for assertion and deassertion.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   raw        : unfiltered input level
//   qual       : qualified level (registered)
module alert_qual #(
  parameter int QUAL_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic qual
);

  localparam int CW = (QUAL_CYC > 1) ? $clog2(QUAL_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUAL_CYC - 1);

  logic [CW-1:0] cnt;

  // cnt counts cycles of disagreement already seen; on the cycle where it
  // holds LAST the disagreement has lasted QUAL_CYC cycles, so flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else if (raw == qual) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      qual <= ~qual;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piezo_alert_sched.sv
// Piezo alert scheduler.
// Qualifies norm_mode / ovr_spd / batt_low, arbitrates them by priority and
// sequences the buzzer as beep (ON) / silence (OFF) bursts with one shared
// down-timer. Over-speed is the only condition that may cut into a running
// beep or silence; everything else waits for the next arbitration point.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   norm_mode    : raw, rider on / normal operation
//   ovr_spd      : raw, over-speed warning
//   batt_low     : raw, battery-low warning
//   mute         : suppresses the normal-mode chirp at arbitration time
//   tone_en      : buzzer on (registered)
//   tone_sel     : 00 none, 01 norm, 10 batt, 11 ovr (registered, 00 when off)
//   alert_active : q_ovr | q_batt, for the status LED
module piezo_alert_sched
  import piezo_pkg::*;
#(
  parameter int QUAL_CYC = 1024,
  parameter int BEEP_CYC = 16777216,
  parameter int GAP_CYC  = 16777216,
  parameter int REST_CYC = 50331648
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       norm_mode,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       mute,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic       alert_active
);

  localparam int TW = $clog2(max3(BEEP_CYC, GAP_CYC, REST_CYC)) + 1;

  // Timer is loaded with N-1 and expires on the cycle it reads zero, giving
  // exactly N cycles in the state.
  localparam logic [TW-1:0] BEEP_LD = TW'(BEEP_CYC - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] REST_LD = TW'(REST_CYC - 1);

  logic q_norm, q_ovr, q_batt, q_ovr_d;

  alert_qual #(.QUAL_CYC(QUAL_CYC)) u_qual_norm (
    .clk(clk), .rst_n(rst_n), .raw(norm_mode), .qual(q_norm)
  );
  alert_qual #(.QUAL_CYC(QUAL_CYC)) u_qual_ovr (
    .clk(clk), .rst_n(rst_n), .raw(ovr_spd), .qual(q_ovr)
  );
  alert_qual #(.QUAL_CYC(QUAL_CYC)) u_qual_batt (
    .clk(clk), .rst_n(rst_n), .raw(batt_low), .qual(q_batt)
  );

  sched_state_t  state;
  tone_sel_t     cur;
  tone_sel_t     sel_q;
  logic [TW-1:0] timer;

  logic      req_any;
  logic      ovr_rise;
  logic      timer_done;
  tone_sel_t next_sel;

  assign next_sel   = pick_req(q_ovr, q_batt, q_norm & ~mute);
  assign req_any    = (next_sel != TONE_NONE);
  assign ovr_rise   = q_ovr & ~q_ovr_d;
  assign timer_done = (timer == '0);

  assign tone_sel     = sel_q;
  assign alert_active = q_ovr | q_batt;

  // Outputs are registered alongside the state so tone_en/tone_sel change on
  // the same edge as the state and never depend combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= TONE_NONE;
      sel_q   <= TONE_NONE;
      tone_en <= 1'b0;
      timer   <= '0;
      q_ovr_d <= 1'b0;
    end else begin
      q_ovr_d <= q_ovr;
      case (state)
        IDLE: begin
          if (req_any) begin
            state   <= ON;
            cur     <= next_sel;
            sel_q   <= next_sel;
            tone_en <= 1'b1;
            timer   <= BEEP_LD;
          end
        end

        ON: begin
          if (ovr_rise && (cur != TONE_OVR)) begin
            // Over-speed cuts a lower-priority beep and starts its own.
            cur   <= TONE_OVR;
            sel_q <= TONE_OVR;
            timer <= BEEP_LD;
          end else if (timer_done) begin
            state   <= OFF;
            sel_q   <= TONE_NONE;
            tone_en <= 1'b0;
            timer   <= (cur == TONE_OVR) ? GAP_LD : REST_LD;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        OFF: begin
          if (ovr_rise) begin
            state   <= ON;
            cur     <= TONE_OVR;
            sel_q   <= TONE_OVR;
            tone_en <= 1'b1;
            timer   <= BEEP_LD;
          end else if (timer_done) begin
            if (req_any) begin
              state   <= ON;
              cur     <= next_sel;
              sel_q   <= next_sel;
              tone_en <= 1'b1;
              timer   <= BEEP_LD;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          sel_q   <= TONE_NONE;
          tone_en <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Directed bench for piezo_alert_sched with QUAL_CYC=4, BEEP_CYC=8,
// GAP_CYC=8, REST_CYC=16.
// Observed word each cycle: {alert_active, tone_en, tone_sel}.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// Interval I0 is the one in which the inputs are applied after reset release;
// a raw level applied in I0 gives a qualified flag in I4 and a tone in I5.
module tb_piezo_alert_sched;

  logic       clk;
  logic       rst_n;
  logic       norm_mode;
  logic       ovr_spd;
  logic       batt_low;
  logic       mute;
  logic       tone_en;
  logic [1:0] tone_sel;
  logic       alert_active;

  int errors;
  int checks;

  piezo_alert_sched #(
    .QUAL_CYC(4),
    .BEEP_CYC(8),
    .GAP_CYC (8),
    .REST_CYC(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .norm_mode   (norm_mode),
    .ovr_spd     (ovr_spd),
    .batt_low    (batt_low),
    .mute        (mute),
    .tone_en     (tone_en),
    .tone_sel    (tone_sel),
    .alert_active(alert_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {alert_active, tone_en, tone_sel};
  endfunction

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, checking the observed word every cycle.
  task automatic run(input string tag, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, obs(), exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    norm_mode = 1'b0;
    ovr_spd   = 1'b0;
    batt_low  = 1'b0;
    mute      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs(), 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Idle after reset with all inputs low
    do_reset();
    run("idle_100", 100, 4'b0000);

    // Normal-mode chirp: 8 on / 16 off, first tone in I5
    do_reset();
    norm_mode = 1'b1;
    run("norm_wait", 4, 4'b0000);
    run("norm_on1", 8, 4'b0101);
    run("norm_rest", 16, 4'b0000);
    run("norm_on2", 8, 4'b0101);

    // 3-cycle batt_low glitch is ignored
    do_reset();
    batt_low = 1'b1;
    run("glitch_hi", 3, 4'b0000);
    batt_low = 1'b0;
    run("glitch_after", 20, 4'b0000);

    // batt_low and ovr_spd together: ovr wins, 8 on / 8 gap
    do_reset();
    batt_low = 1'b1;
    ovr_spd  = 1'b1;
    run("prio_wait", 3, 4'b0000);
    run("prio_alert", 1, 4'b1000);
    run("prio_on1", 8, 4'b1111);
    run("prio_gap", 8, 4'b1000);
    run("prio_on2", 4, 4'b1111);
    // async reset mid-beep silences at once
    rst_n = 1'b0;
    #1;
    check("rst_mid_beep", obs(), 4'b0000);

    // Over-speed qualifies in I7 during a norm beep -> fresh ovr beep from I8
    do_reset();
    norm_mode = 1'b1;
    run("pre_wait", 3, 4'b0000);
    ovr_spd = 1'b1;
    run("pre_wait2", 1, 4'b0000);
    run("pre_norm", 2, 4'b0101);
    run("pre_flag", 1, 4'b1101);
    run("pre_ovr_on", 8, 4'b1111);
    run("pre_ovr_gap", 8, 4'b1000);
    run("pre_ovr_on2", 2, 4'b1111);

    // batt_low qualifying mid norm-beep does not truncate it
    do_reset();
    norm_mode = 1'b1;
    run("bmid_wait", 3, 4'b0000);
    batt_low = 1'b1;
    run("bmid_wait2", 1, 4'b0000);
    run("bmid_norm", 2, 4'b0101);
    run("bmid_norm_al", 6, 4'b1101);
    run("bmid_rest", 16, 4'b1000);
    run("bmid_batt_on", 8, 4'b1110);
    run("bmid_batt_rest", 16, 4'b1000);
    run("bmid_batt_on2", 1, 4'b1110);

    // ovr_spd drops during its beep: beep completes, gap, then idle
    do_reset();
    ovr_spd = 1'b1;
    run("cmp_wait", 3, 4'b0000);
    run("cmp_alert", 1, 4'b1000);
    run("cmp_on_a", 2, 4'b1111);
    ovr_spd = 1'b0;
    run("cmp_on_b", 3, 4'b1111);
    run("cmp_on_c", 3, 4'b0111);
    run("cmp_gap_idle", 28, 4'b0000);

    // Muted norm never beeps; batt still beeps while muted
    do_reset();
    mute      = 1'b1;
    norm_mode = 1'b1;
    run("mute_norm", 40, 4'b0000);
    batt_low = 1'b1;
    run("mute_bwait", 3, 4'b0000);
    run("mute_balert", 1, 4'b1000);
    run("mute_batt_on", 8, 4'b1110);
    run("mute_batt_rest", 16, 4'b1000);
    run("mute_batt_on2", 1, 4'b1110);

    // Mute set mid norm-beep: beep completes, no further norm beeps
    do_reset();
    norm_mode = 1'b1;
    run("mmid_wait", 4, 4'b0000);
    run("mmid_on_a", 2, 4'b0101);
    mute = 1'b1;
    run("mmid_on_b", 6, 4'b0101);
    run("mmid_after", 46, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piezo_alert_sched.md
Name: piezo_alert_sched

Overview:
Alert scheduler that sits ahead of the Segway piezo tone driver. It qualifies the raw norm_mode, ovr_spd and batt_low conditions and arbitrates among them by priority. It then sequences the buzzer as discrete beep/silence bursts, outputting a tone enable plus a tone select that the tone generator maps to 1.5 kHz, 3 kHz or 6.1 kHz. The block owns all timing of when the buzzer sounds; the tone generator only produces the square waves.

Parameters:
QUAL_CYC, 1024, consecutive cycles an input must hold a level before its qualified state changes
BEEP_CYC, 16777216, cycles per beep on-time (~0.34 s at 50 MHz)
GAP_CYC, 16777216, silence after an over-speed beep
REST_CYC, 50331648, silence after a battery-low or normal-mode beep

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
norm_mode  in  1  raw: rider on, normal operation
ovr_spd  in  1  raw: over-speed warning
batt_low  in  1  raw: battery-low warning
mute  in  1  suppresses normal-mode chirp only; warnings are never muted
tone_en  out  1  buzzer on
tone_sel  out  2  00 none, 01 norm (1.5 kHz), 10 batt (3 kHz), 11 ovr (6.1 kHz)
alert_active  out  1  q_ovr | q_batt, for the status LED

Behaviour:
- Reset (async, rst_n low): state IDLE; tone_en=0, tone_sel=00, alert_active=0; all counters 0; qualified flags 0. Reset mid-beep silences the buzzer immediately.
- Qualifier, per input:
  - Saturating counter, cleared whenever the raw input equals the qualified flag.
  - When the counter reaches QUAL_CYC-1 with the input still differing, the flag toggles on the next edge. This applies to both assert and deassert.
  - Raw high from cycle 0 gives flag high at cycle QUAL_CYC.
  - A glitch shorter than QUAL_CYC cycles has no effect.
- Request priority: q_ovr > q_batt > (q_norm & ~mute).
- FSM states: IDLE, ON, OFF. A single down-timer is loaded on each state entry.
  - IDLE: outputs silent. On any request, latch cur = highest request, load BEEP_CYC, go to ON. tone_en goes high one cycle after the flag, i.e. cycle QUAL_CYC+1.
  - ON: tone_en=1, tone_sel=cur. When the timer expires (BEEP_CYC cycles in ON), go to OFF. Load GAP_CYC if cur=ovr, else REST_CYC.
  - OFF: tone_en=0, tone_sel=00. On expiry, re-arbitrate: if a request is present, latch it, load BEEP_CYC, go to ON; else go to IDLE.
- Preemption:
  - q_ovr rising while in ON with cur≠ovr, or while in OFF: next edge enters ON with cur=ovr and the timer reloaded to BEEP_CYC.
  - No other preemption. A lower-priority request never truncates a beep.
  - A source dropping during ON does not cut its beep; the beep completes.
  - mute changes take effect only at the next arbitration.
- Simultaneous qualification of several inputs: the highest priority wins.
- tone_sel=00 whenever tone_en=0. Both outputs come straight from flops (no combinational path from inputs).
- Timer width: $clog2(max(BEEP_CYC,GAP_CYC,REST_CYC))+1. The timer does not wrap.

Decomposition:
- piezo_pkg: tone_sel_t enum (TONE_NONE, TONE_NORM, TONE_BATT, TONE_OVR) and sched_state_t enum (IDLE, ON, OFF).
- One sub-module, alert_qual (parameter QUAL_CYC), instantiated three times.
- FSM, timer and arbitration stay in piezo_alert_sched.

Test Plan:
Bench overrides QUAL_CYC=4, BEEP_CYC=8, GAP_CYC=8, REST_CYC=16.
- Reset/idle: rst_n low, then high with all inputs 0 -> tone_en=0, tone_sel=00, alert_active=0 for 100 cycles; asserting rst_n mid-beep drops tone_en within the same cycle.
- Qualification: norm_mode high at cycle 0 -> tone_en=1, tone_sel=01 at cycle 5, repeating 8 on / 16 off. A 3-cycle batt_low pulse produces no change.
- Priority: batt_low and ovr_spd rise on the same cycle -> first beep tone_sel=11, 8 on / 8 off; alert_active=1 at cycle 4.
- Preemption: during a norm beep (cycle 2 of ON), ovr_spd qualifies -> next cycle tone_sel=11 with a fresh full 8-cycle beep. A batt_low qualifying mid norm-beep does not truncate it; batt plays after the 16-cycle rest.
- Completion: ovr_spd deasserts during ON -> beep completes all 8 cycles, then 8-cycle gap, then IDLE if nothing is pending.
- Mute: mute=1 with only norm_mode qualified -> no beeps. Mute set mid-beep -> that beep completes, and no further norm beeps occur. batt_low still beeps (10) while muted.
